// File: rtl/activation_pkg.sv
// Shared types and constants for the activation stage: activation modes,
// PWL tanh region codes, breakpoints and the region decoder.
package activation_pkg;

    typedef enum logic {
        ACT_RELU = 1'b0,
        ACT_TANH = 1'b1
    } act_type_e;

    typedef enum logic [2:0] {
        R0 = 3'd0,
        R1 = 3'd1,
        R2 = 3'd2,
        R3 = 3'd3,
        R4 = 3'd4
    } tanh_region_e;

    localparam int TANH_BP_NEG_OUTER = -48;
    localparam int TANH_BP_NEG_INNER = -16;
    localparam int TANH_BP_POS_INNER = 16;
    localparam int TANH_BP_POS_OUTER = 48;
    localparam int TANH_SAT          = 32;
    localparam int TANH_INTERCEPT    = 8;

    function automatic tanh_region_e tanh_region(input int x);
        if (x < TANH_BP_NEG_OUTER)      return R0;
        else if (x < TANH_BP_NEG_INNER) return R1;
        else if (x < TANH_BP_POS_INNER) return R2;
        else if (x < TANH_BP_POS_OUTER) return R3;
        else                            return R4;
    endfunction

endpackage

// File: rtl/activation_pipe_if.sv
// Row-stream bundle between the pooling stage, the activation stage and the
// output stage.
interface activation_pipe_if #(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 8,
    parameter int MASK_WIDTH   = 8
);

    logic                           in_data_available;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data;
    logic [MASK_WIDTH-1:0]          validity_mask;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data;
    logic                           out_data_available;
    logic                           done_activation;

    modport master (
        output in_data_available,
        output inp_data,
        output validity_mask,
        input  out_data,
        input  out_data_available,
        input  done_activation
    );

    modport slave (
        input  in_data_available,
        input  inp_data,
        input  validity_mask,
        output out_data,
        output out_data_available,
        output done_activation
    );

endinterface

// File: rtl/activation_lane.sv
// One activation lane: stage 1 captures x, its tanh region, mask and mode;
// stage 2 produces the ReLU / PWL tanh result with mask gating.
module activation_lane
    import activation_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic              i_fire,
    input  logic [DWIDTH-1:0] i_x,
    input  logic              i_mask,
    input  act_type_e         i_type,
    output logic [DWIDTH-1:0] o_y
);

    localparam logic signed [DWIDTH-1:0] K_SAT  = DWIDTH'(TANH_SAT);
    localparam logic signed [DWIDTH-1:0] K_NSAT = DWIDTH'(-TANH_SAT);
    localparam logic signed [DWIDTH-1:0] K_INT  = DWIDTH'(TANH_INTERCEPT);

    logic signed [DWIDTH-1:0] r_x;
    tanh_region_e             r_region;
    logic                     r_mask;
    act_type_e                r_type;
    logic        [DWIDTH-1:0] r_y;

    tanh_region_e             w_region;
    logic signed [DWIDTH-1:0] w_half;
    logic        [DWIDTH-1:0] w_y_next;

    assign w_region = tanh_region(int'($signed(i_x)));
    assign w_half   = r_x >>> 1;

    // The +/-intercept results are only selected inside R1/R3, where they
    // stay within [-32, 32], so DWIDTH-bit arithmetic never wraps.
    always_comb begin
        w_y_next = '0;
        if (r_mask) begin
            if (r_type == ACT_RELU) begin
                w_y_next = r_x[DWIDTH-1] ? '0 : r_x;
            end else begin
                case (r_region)
                    R0:      w_y_next = K_NSAT;
                    R1:      w_y_next = w_half - K_INT;
                    R2:      w_y_next = r_x;
                    R3:      w_y_next = w_half + K_INT;
                    R4:      w_y_next = K_SAT;
                    default: w_y_next = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_x      <= '0;
            r_region <= R0;
            r_mask   <= 1'b0;
            r_type   <= ACT_RELU;
            r_y      <= '0;
        end else begin
            if (i_load) begin
                r_x      <= i_x;
                r_region <= w_region;
                r_mask   <= i_mask;
                r_type   <= i_type;
            end
            if (i_fire) begin
                r_y <= w_y_next;
            end
        end
    end

    assign o_y = r_y;

endmodule

// File: rtl/activation_pipe.sv
// Activation stage: per-lane ReLU / PWL tanh in a 2-cycle pipeline, row
// counting with a sticky done flag, and a combinational bypass when disabled.
module activation_pipe
    import activation_pkg::*;
#(
    parameter int DWIDTH       = 8,
    parameter int MAT_MUL_SIZE = 8,
    parameter int MASK_WIDTH   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_activation,
    input  logic               activation_type,
    activation_pipe_if.slave   bus
);

    localparam int CNT_W = $clog2(MAT_MUL_SIZE) + 1;
    localparam logic [CNT_W-1:0] K_ROWS = CNT_W'(MAT_MUL_SIZE);
    localparam logic [CNT_W-1:0] K_LAST = CNT_W'(MAT_MUL_SIZE - 1);

    logic                           r_v1;
    logic                           r_v2;
    logic [CNT_W-1:0]               r_cnt;
    logic                           r_done;

    logic                           w_clr;
    act_type_e                      w_type;
    logic [MASK_WIDTH-1:0]          w_mask;
    logic [MAT_MUL_SIZE*DWIDTH-1:0] w_y;

    assign w_clr  = reset | ~enable_activation;
    assign w_type = act_type_e'(activation_type);
    assign w_mask = bus.validity_mask;

    for (genvar gi = 0; gi < MAT_MUL_SIZE; gi++) begin : g_lane
        activation_lane #(
            .DWIDTH (DWIDTH)
        ) u_lane (
            .clk    (clk),
            .i_clr  (w_clr),
            .i_load (bus.in_data_available),
            .i_fire (r_v1),
            .i_x    (bus.inp_data[gi*DWIDTH +: DWIDTH]),
            .i_mask (w_mask[gi]),
            .i_type (w_type),
            .o_y    (w_y[gi*DWIDTH +: DWIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_v1 <= bus.in_data_available;
            r_v2 <= r_v1;
            if (r_v2 && (r_cnt != K_ROWS)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_v2 && (r_cnt == K_LAST)) begin
                r_done <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.out_data           = w_y;
        bus.out_data_available = r_v2;
        bus.done_activation    = r_done;
        if (!enable_activation) begin
            bus.out_data           = bus.inp_data;
            bus.out_data_available = bus.in_data_available;
            bus.done_activation    = 1'b1;
        end
    end

endmodule

// File: tb/tb_activation_pipe.sv
// Directed bench for activation_pipe: ReLU/tanh rows, masking, row counting,
// gaps, mid-flight reset and bypass.
module tb_activation_pipe;

    localparam int DW = 8;
    localparam int N  = 8;

    logic clk = 1'b0;
    logic reset;
    logic enable_activation;
    logic activation_type;

    int n_total = 0;
    int n_bad   = 0;

    activation_pipe_if #(.DWIDTH(DW), .MAT_MUL_SIZE(N), .MASK_WIDTH(N)) bus ();

    activation_pipe #(
        .DWIDTH       (DW),
        .MAT_MUL_SIZE (N),
        .MASK_WIDTH   (N)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable_activation (enable_activation),
        .activation_type   (activation_type),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack_row(input int v [8]);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(v[i]);
        return r;
    endfunction

    task automatic idle();
        bus.in_data_available = 1'b0;
        bus.inp_data          = '0;
        bus.validity_mask     = '1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
    endtask

    task automatic single_row(input string tag, input logic [63:0] row, input logic [7:0] mask,
                              input logic typ, input logic [63:0] exp);
        bus.in_data_available = 1'b1;
        bus.inp_data          = row;
        bus.validity_mask     = mask;
        activation_type       = typ;
        tick();
        idle();
        chk({tag, " avail_c1"}, 64'(bus.out_data_available), 64'd0);
        tick();
        chk({tag, " avail_c2"}, 64'(bus.out_data_available), 64'd1);
        chk({tag, " data"}, bus.out_data, exp);
        tick();
        chk({tag, " avail_c3"}, 64'(bus.out_data_available), 64'd0);
    endtask

    // Row c carries the value c in every lane (non-negative, so ReLU passes it).
    task automatic run_pattern(input string name, input logic [31:0] pat, input int len);
        int          avails;
        logic        prev;
        logic [63:0] prev_row;
        avails   = 0;
        prev     = 1'b0;
        prev_row = '0;
        activation_type = 1'b0;
        for (int c = 0; c < len + 6; c++) begin
            bus.in_data_available = (c < len) ? pat[c] : 1'b0;
            bus.inp_data          = {8{8'(c)}};
            bus.validity_mask     = '1;
            tick();
            chk($sformatf("%s avail e%0d", name, c), 64'(bus.out_data_available), 64'(prev));
            chk($sformatf("%s done e%0d", name, c), 64'(bus.done_activation), 64'(avails >= N));
            if (prev) begin
                chk($sformatf("%s data e%0d", name, c), bus.out_data, prev_row);
                avails++;
            end
            prev     = bus.in_data_available;
            prev_row = bus.inp_data;
        end
        idle();
    endtask

    initial begin
        int relu_in  [8] = '{-5, 0, 7, -128, 127, 1, -1, 64};
        int relu_exp [8] = '{0, 0, 7, 0, 127, 1, 0, 64};
        int tanh_in  [8] = '{-100, -48, -20, -16, 15, 20, 47, 100};
        int tanh_exp [8] = '{-32, -32, -18, -16, 15, 18, 31, 32};
        logic [63:0] byp_row;

        reset             = 1'b1;
        enable_activation = 1'b1;
        activation_type   = 1'b0;
        idle();
        tick();
        tick();
        chk("rst out", bus.out_data, 64'd0);
        chk("rst avail", 64'(bus.out_data_available), 64'd0);
        chk("rst done", 64'(bus.done_activation), 64'd0);
        reset = 1'b0;

        single_row("relu", pack_row(relu_in), 8'hFF, 1'b0, pack_row(relu_exp));
        chk("relu done", 64'(bus.done_activation), 64'd0);

        do_reset();
        single_row("tanh", pack_row(tanh_in), 8'hFF, 1'b1, pack_row(tanh_exp));

        // Lanes 1,3,5,7 have mask bit 1 and pass; lanes 0,2,4,6 are forced to 0.
        do_reset();
        single_row("mask tanh", {8{8'd20}}, 8'b1010_1010, 1'b1, 64'h1200_1200_1200_1200);
        single_row("mask relu", {8{8'd20}}, 8'b1010_1010, 1'b0, 64'h1400_1400_1400_1400);

        do_reset();
        run_pattern("burst8", 32'h0000_00FF, 8);

        do_reset();
        run_pattern("gap", 32'h0000_078F, 11);

        do_reset();
        bus.in_data_available = 1'b1;
        bus.inp_data          = {8{8'd5}};
        tick();
        tick();
        reset = 1'b1;
        idle();
        tick();
        chk("midrst avail", 64'(bus.out_data_available), 64'd0);
        chk("midrst done", 64'(bus.done_activation), 64'd0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("midrst drain%0d", k), 64'(bus.out_data_available), 64'd0);
        end
        run_pattern("after_rst", 32'h0000_00FF, 8);

        enable_activation     = 1'b0;
        byp_row               = 64'h8011_7F22_0033_FE44;
        bus.in_data_available = 1'b1;
        bus.inp_data          = byp_row;
        bus.validity_mask     = 8'h00;
        #1;
        chk("byp data", bus.out_data, byp_row);
        chk("byp avail", 64'(bus.out_data_available), 64'd1);
        chk("byp done", 64'(bus.done_activation), 64'd1);
        bus.in_data_available = 1'b0;
        #1;
        chk("byp avail0", 64'(bus.out_data_available), 64'd0);
        tick();
        enable_activation = 1'b1;
        idle();
        tick();
        chk("reen done", 64'(bus.done_activation), 64'd0);
        chk("reen avail", 64'(bus.out_data_available), 64'd0);
        single_row("reen relu", pack_row(relu_in), 8'hFF, 1'b0, pack_row(relu_exp));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
